clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CW, default 16, divide-value and counter width in bits.
REQ-003 SHALL have parameter DIV_INIT, default 4999, divide value loaded into every channel at reset.
REQ-004 SHALL have port clk100m  input  1  sole clock, 100 MHz, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  NCH  per-channel run enable.
REQ-007 SHALL have port ld_valid  input  1  divide-value load request.
REQ-008 SHALL have port ld_ch  input  max(1,clog2(NCH))  target channel of load.
REQ-009 SHALL have port ld_div  input  CW  new divide value.
REQ-010 SHALL have port ld_ready  output  1  load can be accepted.
REQ-011 SHALL have port clk_out  output  NCH  per-channel divided clock, 50% duty.
REQ-012 SHALL have port tick  output  NCH  per-channel one-cycle pulse at each clk_out toggle.

Function
REQ-013 SHALL keep per channel: cnt (CW bits), div_act, div_shadow, pending flag.
REQ-014 SHALL, with en[i]=1 and cnt>=div_act, set cnt<=0, invert clk_out[i], and assert tick[i] on the following cycle only; otherwise cnt<=cnt+1, tick[i]=0.
REQ-015 SHALL produce clk_out frequency f_clk/(2*(div_act+1)); div_act=4999 gives 10 kHz, div_act=0 gives 50 MHz.
REQ-016 SHALL accept a load when ld_valid=1 and ld_ready=1 in the same cycle; the requester holds ld_valid, ld_ch, ld_div stable until acceptance.
REQ-017 SHALL drive ld_ready combinationally as NOT pending[ld_ch]; ld_ch >= NCH SHALL give ld_ready=1 and the load is discarded.
REQ-018 SHALL on acceptance write div_shadow and set pending for channel ld_ch.
REQ-019 SHALL, for an enabled channel, copy div_shadow to div_act and clear pending at the next terminal count (cnt>=div_act), never mid-period; no runt clk_out half-period.
REQ-020 SHALL, when a load is accepted in the same cycle as that channel's terminal count, apply it at the following terminal count, not the current one.
REQ-021 SHALL, with en[i]=0, hold cnt and clk_out[i], keep tick[i]=0, and apply a pending load on the next cycle with cnt<=0.
REQ-022 SHALL on en[i] rising resume counting from the held cnt value and clk_out level.
REQ-023 SHALL keep channels fully independent; loads and enables of one channel SHALL not disturb another.

Reset
REQ-024 SHALL, while rst=1 on a clock edge, set all cnt=0, clk_out=0, tick=0, pending=0, div_act=div_shadow=DIV_INIT; ld_ready=1 after reset.
REQ-025 SHALL discard a load presented in a cycle with rst=1, and abandon any in-progress period.

Configuration
REQ-026 SHALL with macro CLK_DIV_SYNC_EN defined add port sync  input  1; sync=1 SHALL set cnt<=0, clk_out<=0, tick<=0 for all channels and apply all pending loads, giving phase-aligned restart; rst takes priority over sync.
REQ-027 SHALL without CLK_DIV_SYNC_EN omit port sync and all associated logic.

Structure
REQ-028 SHALL place in shared package clk_div_pkg: CW default, constants DIV_10K=4999, DIV_1K=49999, DIV_100HZ=499999 (the latter requiring CW>=19).
REQ-029 SHALL implement one channel as sub-module clk_div_ch (counter, div_act/div_shadow, pending, toggle, tick), instantiated NCH times by generate; top holds load decode and ld_ready mux.

Verification
REQ-030 Reset, en=all 1, DIV_INIT=4999 -> each clk_out toggles every 5000 cycles (10 kHz), tick high exactly 1 cycle per toggle, first toggle at cycle 5000 after reset release.
REQ-031 Load ch1 div=1 mid-period at cnt=2000 -> ch1 completes 5000-cycle half-period, then toggles every 2 cycles; ld_ready for ch1 low until applied; ch0/2/3 unchanged.
REQ-032 Load ch2 div=0 accepted on ch2 terminal-count cycle -> next half-period still 5000 cycles, then clk_out[2] toggles every cycle.
REQ-033 en[3]=0 at cnt=1234 for 100 cycles -> clk_out[3] and cnt frozen, tick[3]=0; resumes, next toggle 3766 cycles after re-enable; pending load during disable applied with cnt=0.
REQ-034 rst pulse mid-operation with pending load on ch0 -> all outputs 0, div_act=4999, pending cleared, ld_ready=1 next cycle.
REQ-035 With CLK_DIV_SYNC_EN, channels at differing phases, sync pulse -> all clk_out=0 next cycle and equal-divisor channels toggle simultaneously thereafter.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider bank: default counter width and
// common divide values for a 100 MHz source clock.
package clk_div_pkg;

    localparam int CLK_DIV_CW = 16;

    // Half-period minus one, in 100 MHz cycles.
    localparam int DIV_10K   = 4999;
    localparam int DIV_1K    = 49999;
    localparam int DIV_100HZ = 499999;   // needs CW >= 19

    // Width of a channel-select field; a single channel still gets one bit.
    function automatic int ch_sel_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: free-running counter, active/shadow divide values,
// pending flag, 50% duty output toggle and a one-cycle tick per toggle.
// Optional phase-align input is present only when CLK_DIV_SYNC_EN is defined.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int            CW       = CLK_DIV_CW,
    parameter logic [CW-1:0] DIV_INIT = CW'(DIV_10K)
) (
    input  logic          i_clk,
    input  logic          i_rst,
`ifdef CLK_DIV_SYNC_EN
    input  logic          i_sync,
`endif
    input  logic          i_en,
    input  logic          i_ld_we,
    input  logic [CW-1:0] i_ld_div,
    output logic          o_pending,
    output logic          o_clk_out,
    output logic          o_tick
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div_act;
    logic [CW-1:0] r_div_shadow;
    logic          r_pending;
    logic          r_clk_out;
    logic          r_tick;
    logic          w_tc;

    // >= rather than == so a counter left above a freshly shrunk divisor
    // still terminates on the next cycle instead of wrapping.
    assign w_tc = (r_cnt >= r_div_act);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_div_act    <= DIV_INIT;
            r_div_shadow <= DIV_INIT;
            r_pending    <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end
`ifdef CLK_DIV_SYNC_EN
        else if (i_sync) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            if (r_pending) begin
                r_div_act <= r_div_shadow;
            end
            r_pending <= i_ld_we;
            if (i_ld_we) begin
                r_div_shadow <= i_ld_div;
            end
        end
`endif
        else begin
            r_tick <= 1'b0;
            if (i_en) begin
                if (w_tc) begin
                    r_cnt     <= '0;
                    r_clk_out <= ~r_clk_out;
                    r_tick    <= 1'b1;
                    if (r_pending) begin
                        r_div_act <= r_div_shadow;
                        r_pending <= 1'b0;
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (r_pending) begin
                // Idle channel has no period to protect: take the new value now.
                r_div_act <= r_div_shadow;
                r_pending <= 1'b0;
                r_cnt     <= '0;
            end
            // A write only arrives while not pending, so it never races the clear above.
            if (i_ld_we) begin
                r_div_shadow <= i_ld_div;
                r_pending    <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers on clk100m with glitch-free divide
// value reloads. Optional sync input enabled by macro CLK_DIV_SYNC_EN.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CW       = CLK_DIV_CW,
    parameter int DIV_INIT = DIV_10K
) (
    input  logic                     clk100m,
    input  logic                     rst,
`ifdef CLK_DIV_SYNC_EN
    input  logic                     sync,
`endif
    input  logic [NCH-1:0]           en,
    input  logic                     ld_valid,
    input  logic [ch_sel_w(NCH)-1:0] ld_ch,
    input  logic [CW-1:0]            ld_div,
    output logic                     ld_ready,
    output logic [NCH-1:0]           clk_out,
    output logic [NCH-1:0]           tick
);

    localparam int LDW = ch_sel_w(NCH);

    logic [NCH-1:0]        w_pending;
    logic [NCH-1:0]        w_ld_we;
    logic [(1<<LDW)-1:0]   w_pend_pad;

    // Load handshake: a transfer happens on a rising edge where ld_valid and
    // ld_ready are both 1. The requester keeps ld_valid/ld_ch/ld_div stable
    // until then; ld_ready is combinational from ld_ch and the target's
    // pending flag. Selects beyond the last channel read as ready and drop.
    always_comb begin
        w_pend_pad          = '0;
        w_pend_pad[NCH-1:0] = w_pending;
    end

    assign ld_ready = ~w_pend_pad[ld_ch];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_ld_we[gi] = ld_valid & ld_ready & (ld_ch == LDW'(gi));

        clk_div_ch #(
            .CW       (CW),
            .DIV_INIT (CW'(DIV_INIT))
        ) u_ch (
            .i_clk     (clk100m),
            .i_rst     (rst),
`ifdef CLK_DIV_SYNC_EN
            .i_sync    (sync),
`endif
            .i_en      (en[gi]),
            .i_ld_we   (w_ld_we[gi]),
            .i_ld_div  (ld_div),
            .o_pending (w_pending[gi]),
            .o_clk_out (clk_out[gi]),
            .o_tick    (tick[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: expected tick edges are queued per
// channel when stimulus is applied and popped as the DUT ticks.
module tb_clk_div_bank;

    localparam int NCH = 4;
    localparam int CW  = 16;

    typedef struct {
        int ch;
        int div;
        int exp_first;
        int exp_period;
    } vec_t;

    logic           clk100m = 1'b0;
    logic           rst;
`ifdef CLK_DIV_SYNC_EN
    logic           sync;
`endif
    logic [NCH-1:0] en;
    logic           ld_valid;
    logic [1:0]     ld_ch;
    logic [CW-1:0]  ld_div;
    logic           ld_ready;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    logic           rst_seen = 1'b1;
    logic [NCH-1:0] prev_clk = '0;
    logic [31:0]    exp_q[NCH][$];
    vec_t           tbl[4];

    always #5 clk100m = ~clk100m;

    clk_div_bank #(.NCH(NCH), .CW(CW), .DIV_INIT(4999)) dut (
        .clk100m  (clk100m),
        .rst      (rst),
`ifdef CLK_DIV_SYNC_EN
        .sync     (sync),
`endif
        .en       (en),
        .ld_valid (ld_valid),
        .ld_ch    (ld_ch),
        .ld_div   (ld_div),
        .ld_ready (ld_ready),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    // ---------------- clock / edge bookkeeping ----------------
    always @(posedge clk100m) begin
        cyc <= cyc + 1;
`ifdef CLK_DIV_SYNC_EN
        rst_seen <= rst | sync;
`else
        rst_seen <= rst;
`endif
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto_edge(input int target);
        while (cyc < target) @(negedge clk100m);
    endtask

    task automatic push_ticks(input int ch, input int first, input int period, input int last);
        for (int t = first; t <= last; t += period) exp_q[ch].push_back(32'(t));
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < NCH; c++)
            check($sformatf("%s_missing_ticks_ch%0d", tag, c), 32'(exp_q[c].size()), 0);
    endtask

    // Load into a disabled channel: ready drops for exactly one cycle.
    task automatic load_disabled(input int ch, input int div);
        ld_valid = 1'b1;
        ld_ch    = 2'(ch);
        ld_div   = 16'(div);
        #1 check($sformatf("ready_idle_ch%0d", ch), 32'(ld_ready), 1);
        @(negedge clk100m);
        ld_valid = 1'b0;
        #1 check($sformatf("ready_pending_ch%0d", ch), 32'(ld_ready), 0);
        @(negedge clk100m);
        #1 check($sformatf("ready_applied_ch%0d", ch), 32'(ld_ready), 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk100m) begin
        for (int c = 0; c < NCH; c++) begin
            if (!rst_seen && (clk_out[c] !== prev_clk[c] || tick[c] !== 1'b0))
                check($sformatf("tick_with_toggle_ch%0d", c), 32'(tick[c]),
                      32'(clk_out[c] !== prev_clk[c]));
            if (tick[c] === 1'b1) begin
                if (exp_q[c].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tick_ch%0d: got tick at edge %0d expected none", c, cyc);
                end else begin
                    check($sformatf("tick_edge_ch%0d", c), 32'(cyc), exp_q[c].pop_front());
                end
            end
            prev_clk[c] = clk_out[c];
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout at edge %0d expected completion", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int r0;
        int r2;
        int e;
`ifdef CLK_DIV_SYNC_EN
        int g;
        int y;
`endif
        tbl[0] = '{ch: 0, div: 2, exp_first: 3, exp_period: 3};
        tbl[1] = '{ch: 1, div: 0, exp_first: 1, exp_period: 1};
        tbl[2] = '{ch: 2, div: 7, exp_first: 8, exp_period: 8};
        tbl[3] = '{ch: 3, div: 4, exp_first: 5, exp_period: 5};

        rst      = 1'b1;
        en       = '0;
        ld_valid = 1'b0;
        ld_ch    = '0;
        ld_div   = '0;
`ifdef CLK_DIV_SYNC_EN
        sync     = 1'b0;
`endif
        goto_edge(3);
        check("reset_clk_out", 32'(clk_out), 0);
        check("reset_tick", 32'(tick), 0);
        check("reset_ld_ready", 32'(ld_ready), 1);

        // Window 1: default 10 kHz, mid-period reload, reload on terminal count, pause.
        r0  = cyc;
        rst = 1'b0;
        en  = '1;
        push_ticks(0, r0 + 5000, 5000, r0 + 12000);
        push_ticks(1, r0 + 5000, 2, r0 + 12000);
        push_ticks(2, r0 + 5000, 5000, r0 + 10000);
        push_ticks(2, r0 + 10001, 1, r0 + 12000);
        push_ticks(3, r0 + 5100, 5000, r0 + 12000);

        goto_edge(r0 + 1234);
        en[3] = 1'b0;
        goto_edge(r0 + 1334);
        check("pause_clk_out_ch3", 32'(clk_out[3]), 0);
        en[3] = 1'b1;

        goto_edge(r0 + 2000);
        ld_valid = 1'b1;
        ld_ch    = 2'd1;
        ld_div   = 16'd1;
        #1 check("ready_mid_ch1", 32'(ld_ready), 1);
        goto_edge(r0 + 2001);
        ld_valid = 1'b0;
        #1 check("pending_mid_ch1", 32'(ld_ready), 0);

        goto_edge(r0 + 4999);
        check("pending_held_ch1", 32'(ld_ready), 0);
        ld_valid = 1'b1;
        ld_ch    = 2'd2;
        ld_div   = 16'd0;
        #1 check("ready_tc_ch2", 32'(ld_ready), 1);
        goto_edge(r0 + 5000);
        ld_valid = 1'b0;
        ld_ch    = 2'd1;
        #1 check("applied_ch1", 32'(ld_ready), 1);
        ld_ch = 2'd2;
        #1 check("pending_tc_ch2", 32'(ld_ready), 0);
        goto_edge(r0 + 9999);
        check("pending_held_ch2", 32'(ld_ready), 0);
        goto_edge(r0 + 10000);
        check("applied_ch2", 32'(ld_ready), 1);

        goto_edge(r0 + 10999);
        ld_valid = 1'b1;
        ld_ch    = 2'd0;
        ld_div   = 16'd9;
        goto_edge(r0 + 11000);
        ld_valid = 1'b0;
        #1 check("pending_ch0_before_rst", 32'(ld_ready), 0);

        // Reset mid-operation with a load offered during the reset cycle.
        goto_edge(r0 + 12000);
        rst      = 1'b1;
        ld_valid = 1'b1;
        ld_ch    = 2'd3;
        ld_div   = 16'd2;
        goto_edge(r0 + 12001);
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_tick", 32'(tick), 0);
        drain("w1");
        r2       = cyc;
        rst      = 1'b0;
        ld_valid = 1'b0;
        ld_ch    = 2'd0;
        #1 check("rst_clears_pending_ch0", 32'(ld_ready), 1);
        ld_ch = 2'd3;
        #1 check("rst_discards_load_ch3", 32'(ld_ready), 1);

        // Window 2: park counters mid-period, load while disabled, restart from zero.
        goto_edge(r2 + 300);
        en = '0;
        for (int k = 0; k < 4; k++) load_disabled(tbl[k].ch, tbl[k].div);
        @(negedge clk100m);
        e  = cyc;
        en = '1;
        for (int k = 0; k < 4; k++)
            push_ticks(tbl[k].ch, e + tbl[k].exp_first, tbl[k].exp_period, e + 200);
        goto_edge(e + 200);
        en = '0;
        goto_edge(e + 205);
        drain("w2");

`ifdef CLK_DIV_SYNC_EN
        // Window 3: staggered phases, pending load, then a phase-align pulse.
        for (int c = 0; c < NCH; c++) load_disabled(c, 5);
        @(negedge clk100m);
        g = cyc;
        for (int c = 0; c < NCH; c++) begin
            push_ticks(c, g + c + 6, 6, g + 19);
            en[c] = 1'b1;
            if (c < NCH - 1) @(negedge clk100m);
        end
        goto_edge(g + 18);
        ld_valid = 1'b1;
        ld_ch    = 2'd0;
        ld_div   = 16'd2;
        #1 check("ready_presync_ch0", 32'(ld_ready), 1);
        goto_edge(g + 19);
        ld_valid = 1'b0;
        sync     = 1'b1;
        goto_edge(g + 20);
        y    = cyc;
        sync = 1'b0;
        check("sync_clk_out", 32'(clk_out), 0);
        check("sync_tick", 32'(tick), 0);
        check("sync_applies_pending_ch0", 32'(ld_ready), 1);
        drain("presync");
        push_ticks(0, y + 3, 3, y + 60);
        for (int c = 1; c < NCH; c++) push_ticks(c, y + 6, 6, y + 60);
        goto_edge(y + 60);
        en = '0;
        goto_edge(y + 65);
        drain("w3");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
